// File: rtl/uart_hex_parser_if.sv
// Parsed-word stream from the hex line parser to the host-side command logic.
interface uart_hex_parser_if #(
    parameter int WIDTH = 32
);
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic [6:0]       o_ndig;
    logic             o_trunc;

    modport master (output o_valid, o_data, o_ndig, o_trunc, input o_ready);
    modport slave  (input o_valid, o_data, o_ndig, o_trunc, output o_ready);
endinterface

// File: rtl/uart_hex_parser.sv
// Parses newline-terminated ASCII hex lines from a UART byte stream into WIDTH-bit words.
// Malformed lines, and lines finishing while the output slot is busy, are dropped and counted.
module uart_hex_parser #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    uart_hex_parser_if.master        o_bus,
    output logic                     err,
    output logic [7:0]               drop_cnt
);
    localparam int         MAXD   = WIDTH / 4;
    localparam logic [6:0] MAXD_C = 7'(MAXD);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SKIP} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [6:0]       r_cnt;
    logic             r_ltrunc;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [6:0]       r_ndig;
    logic             r_trunc;
    logic             r_err;
    logic [7:0]       r_drop;

    logic             w_is_hex;
    logic             w_is_term;
    logic [3:0]       w_nib;
    logic             w_accept;
    logic             w_slot_free;
    logic [WIDTH-1:0] w_shift;

    always_comb begin
        w_is_hex  = 1'b0;
        w_is_term = (rx_data == 8'h0A) || (rx_data == 8'h0D);
        w_nib     = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(rx_data - 8'h30);
        end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(rx_data - 8'h57);
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(rx_data - 8'h37);
        end
    end

    assign w_accept    = r_valid & o_bus.o_ready;
    assign w_slot_free = ~r_valid | w_accept;
    // Shift form avoids a zero-width slice when WIDTH == 4.
    assign w_shift     = (r_acc << 4) | WIDTH'(w_nib);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ltrunc <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_ndig   <= '0;
            r_trunc  <= 1'b0;
            r_err    <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) r_valid <= 1'b0;
            if (rx_done) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_is_hex) begin
                            r_acc   <= WIDTH'(w_nib);
                            r_cnt   <= 7'd1;
                            r_state <= S_COLLECT;
                        end else if (!w_is_term) begin
                            r_state <= S_SKIP;
                        end
                    end
                    S_COLLECT: begin
                        if (w_is_hex) begin
                            r_acc <= w_shift;
                            if (r_cnt == MAXD_C) r_ltrunc <= 1'b1;
                            else                 r_cnt    <= r_cnt + 7'd1;
                        end else begin
                            if (w_is_term) begin
                                if (w_slot_free) begin
                                    r_valid <= 1'b1;
                                    r_data  <= r_acc;
                                    r_ndig  <= r_cnt;
                                    r_trunc <= r_ltrunc;
                                end else begin
                                    r_err <= 1'b1;
                                    if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
                                end
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_SKIP;
                            end
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_ltrunc <= 1'b0;
                        end
                    end
                    S_SKIP: begin
                        if (w_is_term) begin
                            r_err   <= 1'b1;
                            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_bus.o_valid = r_valid;
    assign o_bus.o_data  = r_data;
    assign o_bus.o_ndig  = r_ndig;
    assign o_bus.o_trunc = r_trunc;
    assign err           = r_err;
    assign drop_cnt      = r_drop;
endmodule
